// File: rtl/train_track_fsm_if.sv
// Signal bundle between the two-train track controller and its surroundings.
// Sensors and fault_clear are level inputs and the rest are registered outputs; nothing here uses valid/ready.
interface train_track_fsm_if;
  logic       sensor_a;
  logic       sensor_b;
  logic       sensor_exit;
  logic       fault_clear;
  logic [1:0] DA;
  logic [1:0] DB;
  logic       sw1;
  logic       sw2;
  logic       fault;
  logic [3:0] Present_State;

  modport slave (
    input  sensor_a, sensor_b, sensor_exit, fault_clear,
    output DA, DB, sw1, sw2, fault, Present_State
  );

  modport master (
    output sensor_a, sensor_b, sensor_exit, fault_clear,
    input  DA, DB, sw1, sw2, fault, Present_State
  );
endinterface

// File: rtl/train_track_fsm.sv
// Moore controller for two trains sharing one track segment, with sensor sync/edge front end and occupancy timeout.
// Optional sensor debounce is enabled by defining TRAIN_DEBOUNCE_EN.
module train_track_fsm #(
  parameter int unsigned TIMEOUT_CYCLES  = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic              clk,
  input  logic              reset,
  train_track_fsm_if.slave  bus
);

  typedef enum logic [3:0] {
    S_ABOUT = 4'h1,
    S_AIN   = 4'h2,
    S_BIN   = 4'h3,
    S_ASTOP = 4'h4,
    S_BSTOP = 4'h5,
    S_FAULT = 4'hE
  } state_t;

  localparam int unsigned TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  // Sensor index: 0 = sensor_a, 1 = sensor_b, 2 = sensor_exit.
  logic [2:0] w_raw;
  logic [2:0] w_level;
  logic [2:0] r_s1;
  logic [2:0] r_s2;
  logic [2:0] r_prev;
  logic [2:0] r_arm;
  logic [2:0] r_pulse;
  logic       r_run;

  assign w_raw = {bus.sensor_exit, bus.sensor_b, bus.sensor_a};

`ifdef TRAIN_DEBOUNCE_EN
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES);

  logic [DW-1:0] r_db_cnt [3];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset || !r_s2[i]) begin
        r_db_cnt[i] <= '0;
      end else if (r_db_cnt[i] != DB_MAX) begin
        r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    w_level = '0;
    for (int i = 0; i < 3; i++) begin
      w_level[i] = (r_db_cnt[i] == DB_MAX);
    end
  end
`else
  assign w_level = r_s2;
`endif

  // r_arm stays low until a sensor has been seen low after reset, so a pin held through release never pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_prev  <= '0;
      r_arm   <= '0;
      r_pulse <= '0;
      r_run   <= 1'b0;
    end else begin
      r_s1    <= w_raw;
      r_s2    <= r_s1;
      r_run   <= 1'b1;
      r_arm   <= r_arm | ({3{r_run}} & ~r_s1);
      r_prev  <= w_level;
      r_pulse <= w_level & ~r_prev & r_arm;
    end
  end

  logic w_pa;
  logic w_pb;
  logic w_px;
  assign w_pa = r_pulse[0];
  assign w_pb = r_pulse[1];
  assign w_px = r_pulse[2];

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_tmo;
  logic          w_active;
  logic [1:0]    w_da;
  logic [1:0]    w_db;
  logic          w_sw1;
  logic          w_sw2;
  logic          w_fault;
  logic [1:0]    r_da;
  logic [1:0]    r_db;
  logic          r_sw1;
  logic          r_sw2;
  logic          r_fault;

  assign w_active = (r_state == S_AIN) || (r_state == S_BIN) ||
                    (r_state == S_ASTOP) || (r_state == S_BSTOP);

  // State register, registered outputs and occupancy timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_ABOUT;
      r_da    <= 2'b01;
      r_db    <= 2'b01;
      r_sw1   <= 1'b0;
      r_sw2   <= 1'b0;
      r_fault <= 1'b0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_next;
      r_da    <= w_da;
      r_db    <= w_db;
      r_sw1   <= w_sw1;
      r_sw2   <= w_sw2;
      r_fault <= w_fault;
      if (w_next != r_state || !w_active) begin
        r_tmo <= '0;
      end else if (r_tmo != TMO_MAX) begin
        r_tmo <= r_tmo + 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_ABOUT: begin
        if (w_pa)      w_next = w_pb ? S_BSTOP : S_AIN;
        else if (w_pb) w_next = S_BIN;
      end
      S_AIN: begin
        if (w_pb)      w_next = S_BSTOP;
        else if (w_px) w_next = S_ABOUT;
      end
      S_BIN: begin
        if (w_pa)      w_next = S_ASTOP;
        else if (w_px) w_next = S_ABOUT;
      end
      S_ASTOP: if (w_px) w_next = S_AIN;
      S_BSTOP: if (w_px) w_next = S_BIN;
      S_FAULT: if (bus.fault_clear) w_next = S_ABOUT;
      default: w_next = S_FAULT;
    endcase
    // An expired occupancy timer wins over any pulse arriving the same cycle.
    if (w_active && r_tmo == TMO_MAX) w_next = S_FAULT;
  end

  always_comb begin
    w_da    = 2'b00;
    w_db    = 2'b00;
    w_sw1   = 1'b0;
    w_sw2   = 1'b0;
    w_fault = 1'b0;
    case (w_next)
      S_ABOUT, S_AIN: begin
        w_da = 2'b01;
        w_db = 2'b01;
      end
      S_BIN: begin
        w_da  = 2'b01;
        w_db  = 2'b01;
        w_sw1 = 1'b1;
        w_sw2 = 1'b1;
      end
      S_ASTOP: begin
        w_db  = 2'b01;
        w_sw1 = 1'b1;
        w_sw2 = 1'b1;
      end
      S_BSTOP: w_da = 2'b01;
      default: w_fault = 1'b1;
    endcase
  end

  assign bus.Present_State = r_state;
  assign bus.DA            = r_da;
  assign bus.DB            = r_db;
  assign bus.sw1           = r_sw1;
  assign bus.sw2           = r_sw2;
  assign bus.fault         = r_fault;

endmodule

// File: tb/tb_train_track_fsm.sv
// Directed bench for train_track_fsm: vector table for the route sequences plus hand-written timeout, fault and reset cases.
// Honours TRAIN_DEBOUNCE_EN when it is defined for the build.
module tb_train_track_fsm;
  localparam int TMO = 20;
  localparam int DEB = 4;
`ifdef TRAIN_DEBOUNCE_EN
  localparam int LAT = 4 + DEB;
`else
  localparam int LAT = 4;
`endif
  localparam int NV = 27;

  typedef struct {
    logic       sa;
    logic       sb;
    logic       sx;
    logic       fc;
    int         ncyc;
    logic [3:0] st;
    logic [1:0] da;
    logic [1:0] db;
    logic       sw1;
    logic       sw2;
    logic       flt;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  logic [10:0] exp_q[$];
  vec_t vecs[NV];

  always #5 clk = ~clk;

  train_track_fsm_if bus();

  train_track_fsm #(
    .TIMEOUT_CYCLES (TMO),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic sa, input logic sb, input logic sx, input logic fc);
    bus.sensor_a    = sa;
    bus.sensor_b    = sb;
    bus.sensor_exit = sx;
    bus.fault_clear = fc;
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] st, input logic [1:0] da,
                         input logic [1:0] db, input logic sw1, input logic sw2, input logic flt);
    chk({tag, ".state"}, bus.Present_State, st);
    chk({tag, ".DA"},    {2'b00, bus.DA}, {2'b00, da});
    chk({tag, ".DB"},    {2'b00, bus.DB}, {2'b00, db});
    chk({tag, ".sw1"},   {3'b000, bus.sw1}, {3'b000, sw1});
    chk({tag, ".sw2"},   {3'b000, bus.sw2}, {3'b000, sw2});
    chk({tag, ".fault"}, {3'b000, bus.fault}, {3'b000, flt});
  endtask

  function automatic vec_t mk(input logic sa, input logic sb, input logic sx, input logic fc,
                              input int n, input logic [3:0] st, input logic [1:0] da,
                              input logic [1:0] db, input logic sw1, input logic sw2,
                              input logic flt);
    vec_t v;
    v.sa = sa; v.sb = sb; v.sx = sx; v.fc = fc; v.ncyc = n;
    v.st = st; v.da = da; v.db = db; v.sw1 = sw1; v.sw2 = sw2; v.flt = flt;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    //                sa    sb    sx    fc   cycles   st     DA     DB   sw1   sw2   flt
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1,       4'h1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, LAT - 1, 4'h1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1,       4'h2, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 3,       4'h2, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 1'b1, 1'b0, LAT,     4'h1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 1'b1, 1'b0, 1'b0, LAT,     4'h3, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 1'b0, 1'b0, LAT,     4'h4, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 1'b1, 1'b0, LAT,     4'h2, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, LAT,     4'h5, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 1'b1, 1'b0, LAT,     4'h3, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, LAT,     4'h3, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0);
    vecs[11] = mk(1'b1, 1'b0, 1'b1, 1'b0, LAT,     4'h4, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, LAT,     4'h4, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0);
    vecs[13] = mk(1'b0, 1'b0, 1'b1, 1'b0, LAT,     4'h2, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, LAT,     4'h2, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    vecs[15] = mk(1'b0, 1'b1, 1'b1, 1'b0, LAT,     4'h5, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, LAT,     4'h5, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    vecs[17] = mk(1'b0, 1'b0, 1'b1, 1'b0, LAT,     4'h3, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0);
    vecs[18] = mk(1'b0, 1'b0, 1'b0, 1'b0, LAT,     4'h3, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0);
    vecs[19] = mk(1'b0, 1'b0, 1'b1, 1'b0, LAT,     4'h1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    vecs[20] = mk(1'b0, 1'b0, 1'b0, 1'b0, LAT,     4'h1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    vecs[21] = mk(1'b1, 1'b1, 1'b0, 1'b0, LAT,     4'h5, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    vecs[22] = mk(1'b0, 1'b0, 1'b0, 1'b0, LAT,     4'h5, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    vecs[23] = mk(1'b0, 1'b0, 1'b1, 1'b0, LAT,     4'h3, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0);
    vecs[24] = mk(1'b0, 1'b0, 1'b0, 1'b0, LAT,     4'h3, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0);
    vecs[25] = mk(1'b0, 1'b0, 1'b1, 1'b0, LAT,     4'h1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    vecs[26] = mk(1'b0, 1'b0, 1'b0, 1'b0, LAT,     4'h1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);

    // Clock/reset: hold reset two cycles with all sensors low.
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);
    chk_out("reset", 4'h1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      logic [10:0] e;
      drive(vecs[i].sa, vecs[i].sb, vecs[i].sx, vecs[i].fc);
      exp_q.push_back({vecs[i].st, vecs[i].da, vecs[i].db, vecs[i].sw1, vecs[i].sw2, vecs[i].flt});
      tick(vecs[i].ncyc);
      e = exp_q.pop_front();
      chk_out($sformatf("v%0d", i), e[10:7], e[6:5], e[4:3], e[2], e[1], e[0]);
    end

`ifdef TRAIN_DEBOUNCE_EN
    // A two-cycle glitch is shorter than the debounce window.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick(2);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick(LAT + 4);
    chk("glitch.state", bus.Present_State, 4'h1);
`endif

    // Occupancy timeout from AIN: still AIN after TMO cycles, FAULT one cycle later.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick(LAT);
    chk("tmo_enter.state", bus.Present_State, 4'h2);
    tick(TMO);
    chk("tmo_before.state", bus.Present_State, 4'h2);
    tick(1);
    chk_out("tmo_fault", 4'hE, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

    // FAULT ignores every sensor until fault_clear.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    tick(LAT);
    chk("fault_pb.state", bus.Present_State, 4'hE);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    tick(LAT);
    chk("fault_px.state", bus.Present_State, 4'hE);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick(LAT);
    chk("fault_pa.state", bus.Present_State, 4'hE);
    chk("fault_pa.fault", {3'b000, bus.fault}, 4'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick(LAT);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);
    chk_out("fault_clear", 4'h1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);

    // Reset in ASTOP with sensor_a held high: ABOUT next edge, no pulse after release.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    tick(LAT);
    chk("rst_bin.state", bus.Present_State, 4'h3);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick(LAT);
    chk_out("rst_astop", 4'h4, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    tick(1);
    chk_out("rst_mid", 4'h1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick(LAT + 4);
    chk_out("rst_held_a", 4'h1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick(LAT);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick(LAT);
    chk("rst_rearm.state", bus.Present_State, 4'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
